// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Optional lock feature is enabled by defining UART_ARB_LOCK_EN.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after last,
// wrapping modulo N.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(last) + k) % N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NREQ requesters.
// Define UART_ARB_LOCK_EN to add req_lock (bounded regrant of the owner).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ          = 4,
  parameter  int GAP_BITS      = 2,
  parameter  int TIMEOUT_TICKS = 16,
  localparam int GW            = idx_w(NREQ),
  localparam int DW            = UART_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    req_ready,
  input  logic               tick,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_done,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               err
);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [GW-1:0] gid_q, gid_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    wd_q, wd_d;
  logic [3:0]    gap_q, gap_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] pk_gnt;
  logic [GW-1:0]   pk_idx;
  logic            pk_any;

  logic [NREQ-1:0] win_oh;
  logic [GW-1:0]   win_idx;
  logic            win_any;
  logic            lock_hit;

  uart_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pk_gnt),
    .idx  (pk_idx),
    .any  (pk_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic [1:0] lock_cnt_q, lock_cnt_d;

  // Owner keeps the grant while locked, capped at 3 regrants.
  always_comb begin
    lock_hit = req_lock[gid_q]
             && req_valid[gid_q]
             && (lock_cnt_q != 2'd3);
    win_any  = pk_any;
    win_idx  = pk_idx;
    win_oh   = pk_gnt;
    if (lock_hit) begin
      win_idx = gid_q;
      win_oh  = NREQ'(1) << gid_q;
    end
  end
`else
  always_comb begin
    lock_hit = 1'b0;
    win_any  = pk_any;
    win_idx  = pk_idx;
    win_oh   = pk_gnt;
  end
`endif

  // No accept strobe while reset holds the FSM.
  assign req_ready = (state_q == IDLE && !rst)
                   ? win_oh : '0;

  assign tx_start = (state_q == START);
  assign busy     = (state_q != IDLE);
  assign tx_data  = data_q;
  assign grant_id = gid_q;
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          data_d  = req_data[int'(win_idx)*DW +: DW];
          gid_d   = win_idx;
          last_d  = win_idx;
          state_d = START;
`ifdef UART_ARB_LOCK_EN
          lock_cnt_d = lock_hit
                     ? lock_cnt_q + 2'd1
                     : 2'd0;
`endif
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tick) begin
          wd_d = wd_q + 8'd1;
        end
        // A done pulse beats a coincident final timeout tick.
        if (tx_done
            || (tick && wd_q == 8'(TIMEOUT_TICKS - 1))) begin
          err_d = !tx_done;
          gap_d = '0;
          if (GAP_BITS == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == 4'(GAP_BITS - 1)) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= GW'(NREQ - 1);
      wd_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

endmodule
